// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the execution controller.
//   - state_t      : controller FSM state encoding
//   - field slices : bit positions of the 16-bit instruction word
//   - OP_HALT      : opcode that halts when paired with imm_sel=1
//   - exec_dbg_t   : debug view of FSM state and captured ALU result
//   - op_updates_cy: which opcodes load the external carry register
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int INSTR_W  = 16;
  localparam int NUM_REGS = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Instruction word: [15] imm_sel, [14:12] op, [11] ci_en, [10] wb_en,
  // [9:8] rd, [7:0] imm; rs is [1:0] when imm_sel=0.
  localparam int IMM_SEL_BIT = 15;
  localparam int OP_HI       = 14;
  localparam int OP_LO       = 12;
  localparam int CI_EN_BIT   = 11;
  localparam int WB_EN_BIT   = 10;
  localparam int RD_HI       = 9;
  localparam int RD_LO       = 8;
  localparam int IMM_HI      = 7;
  localparam int IMM_LO      = 0;
  localparam int RS_HI       = 1;
  localparam int RS_LO       = 0;

  localparam logic [2:0] OP_HALT = 3'b111;

  typedef struct packed {
    state_t            state;
    logic [DATA_W-1:0] res;
    logic              res_cy;
  } exec_dbg_t;

  // Carry register is loaded for op 000 and 010..101 only.
  function automatic logic op_updates_cy(input logic [2:0] op);
    return (op == 3'b000) || ((op >= 3'b010) && (op <= 3'b101));
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// exec_ctrl_if: instruction-fetch bus between the controller and the
// instruction memory.
//   instr_addr : address being fetched (controller -> memory)
//   instr_req  : fetch request          (controller -> memory)
//   instr_ack  : fetch acknowledge      (memory -> controller)
//   instr      : instruction word       (memory -> controller)
// Handshake: instr_req is a valid, instr_ack its ready; a word transfers on
// a rising edge where both are high. While instr_req is high the address is
// held stable; instr_ack with instr_req low carries no meaning and is ignored.
interface exec_ctrl_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0]  instr_addr;
  logic               instr_req;
  logic               instr_ack;
  logic [INSTR_W-1:0] instr;

  modport master (output instr_addr, output instr_req,
                  input  instr_ack,  input  instr);
  modport slave  (input  instr_addr, input  instr_req,
                  output instr_ack,  output instr);
endinterface

// File: rtl/exec_regfile.sv
// exec_regfile: 4 x 8-bit register file R0..R3.
//   clk, rst_n : clock, asynchronous active-low reset (clears all registers)
//   we, wa, wd : synchronous write enable / address / data
//   ra, rd_a   : asynchronous read port A
//   rb, rd_b   : asynchronous read port B
module exec_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [1:0]        ra,
  output logic [DATA_W-1:0] rd_a,
  input  logic [1:0]        rb,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = regs[ra];
  assign rd_b = regs[rb];

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle execution controller.
// Fetches 16-bit instructions, drives an external ALU and writes results back
// into a 4-entry register file. IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH;
// imm_sel=1 with op=111 parks in HALT, restart continues at the next PC.
// Optional feature: define EXEC_CTRL_ZFLAG_EN to add z_o (zero flag of the
// last written-back result).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start_i                 : leave IDLE/HALT
//   instr_addr_o/req_o      : fetch address and request (PC)
//   instr_ack_i/instr_i     : fetch acknowledge and instruction word
//   alu_a_o/b_o/op_o/ci_o   : registered ALU operands, op and carry-in
//   alu_out_i/alu_cy_i      : ALU result and carry-out
//   cy_i/cy_ce_o            : external carry register value / load enable
//   busy_o/halted_o         : executing / halted status
//   z_o                     : zero flag (EXEC_CTRL_ZFLAG_EN only)
//   dbg_o                   : FSM state and captured ALU result
module exec_ctrl
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic [DATA_W-1:0]  instr_addr_o,
  output logic               instr_req_o,
  input  logic               instr_ack_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [DATA_W-1:0]  alu_a_o,
  output logic [DATA_W-1:0]  alu_b_o,
  output logic [2:0]         alu_op_o,
  output logic               alu_ci_o,
  input  logic [DATA_W-1:0]  alu_out_i,
  input  logic               alu_cy_i,
  input  logic               cy_i,
  output logic               cy_ce_o,
  output logic               busy_o,
  output logic               halted_o,
`ifdef EXEC_CTRL_ZFLAG_EN
  output logic               z_o,
`endif
  output exec_dbg_t          dbg_o
);

  state_t             state;
  logic [DATA_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  res;
  logic               res_cy;

  // Decoded fields of the latched instruction
  logic              ir_imm_sel;
  logic [2:0]        ir_op;
  logic              ir_ci_en;
  logic              ir_wb_en;
  logic [1:0]        ir_rd;
  logic [1:0]        ir_rs;
  logic [DATA_W-1:0] ir_imm;

  assign ir_imm_sel = ir[IMM_SEL_BIT];
  assign ir_op      = ir[OP_HI:OP_LO];
  assign ir_ci_en   = ir[CI_EN_BIT];
  assign ir_wb_en   = ir[WB_EN_BIT];
  assign ir_rd      = ir[RD_HI:RD_LO];
  assign ir_rs      = ir[RS_HI:RS_LO];
  assign ir_imm     = ir[IMM_HI:IMM_LO];

  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic              rf_we;

  // rd is both the A operand and the write-back destination
  assign rf_we = (state == S_WB) && ir_wb_en;

  exec_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .wa    (ir_rd),
    .wd    (res),
    .ra    (ir_rd),
    .rd_a  (rf_a),
    .rb    (ir_rs),
    .rd_b  (rf_b)
  );

  // PC only changes on an accepted fetch, so the address is stable while
  // a request waits for its acknowledge.
  assign instr_addr_o = pc;
  assign dbg_o        = {state, res, res_cy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      res         <= '0;
      res_cy      <= 1'b0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      alu_op_o    <= '0;
      alu_ci_o    <= 1'b0;
      instr_req_o <= 1'b0;
      cy_ce_o     <= 1'b0;
      busy_o      <= 1'b0;
      halted_o    <= 1'b0;
`ifdef EXEC_CTRL_ZFLAG_EN
      z_o         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            state       <= S_FETCH;
            instr_req_o <= 1'b1;
            busy_o      <= 1'b1;
            halted_o    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (instr_ack_i) begin
            ir          <= instr_i;
            pc          <= pc + 8'd1;
            instr_req_o <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (ir_imm_sel && (ir_op == OP_HALT)) begin
            state    <= S_HALT;
            busy_o   <= 1'b0;
            halted_o <= 1'b1;
          end else begin
            alu_a_o  <= rf_a;
            alu_b_o  <= ir_imm_sel ? ir_imm : rf_b;
            alu_op_o <= ir_op;
            alu_ci_o <= ir_ci_en & cy_i;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          res     <= alu_out_i;
          res_cy  <= alu_cy_i;
          // Raised on entry to WB so the pulse covers exactly the WB cycle
          cy_ce_o <= op_updates_cy(ir_op);
          state   <= S_WB;
        end
        S_WB: begin
          cy_ce_o     <= 1'b0;
          instr_req_o <= 1'b1;
          state       <= S_FETCH;
`ifdef EXEC_CTRL_ZFLAG_EN
          if (ir_wb_en) z_o <= (res == '0);
`endif
        end
        default: begin
          state       <= S_IDLE;
          instr_req_o <= 1'b0;
          cy_ce_o     <= 1'b0;
          busy_o      <= 1'b0;
          halted_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed testbench for exec_ctrl with a stub ALU, an external
// carry register and a hand-driven instruction bus.
module tb_exec_ctrl;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  exec_ctrl_if bus ();
  logic       start;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic       alu_ci, alu_cy;
  logic       cy_reg, cy_ce, busy, halted;
  exec_dbg_t  dbg;
`ifdef EXEC_CTRL_ZFLAG_EN
  logic       z;
`endif

  int vectors     = 0;
  int miscompares = 0;

  exec_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .instr_addr_o (bus.instr_addr),
    .instr_req_o  (bus.instr_req),
    .instr_ack_i  (bus.instr_ack),
    .instr_i      (bus.instr),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_ci_o     (alu_ci),
    .alu_out_i    (alu_out),
    .alu_cy_i     (alu_cy),
    .cy_i         (cy_reg),
    .cy_ce_o      (cy_ce),
    .busy_o       (busy),
    .halted_o     (halted),
`ifdef EXEC_CTRL_ZFLAG_EN
    .z_o          (z),
`endif
    .dbg_o        (dbg)
  );

  // Stub ALU (environment, not a model of the controller)
  always_comb begin
    alu_out = '0;
    alu_cy  = 1'b0;
    case (alu_op)
      3'b000:  {alu_cy, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
      3'b001:  {alu_cy, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = alu_a ^ alu_b;
      default: alu_out = alu_b;
    endcase
  end

  // External carry register loaded by cy_ce_o
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cy_reg <= 1'b0;
    else if (cy_ce) cy_reg <= alu_cy;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_t s);
    check(tag, 16'(dbg.state), 16'(s));
  endtask

  // Serve one fetch: wait (bounded) for the request, hold off 'delay' cycles
  // checking address stability, then acknowledge with 'word'. Returns at the
  // negedge after the accepting edge (controller in DECODE).
  task automatic fetch(input logic [15:0] word, input int delay, input logic [7:0] exp_pc);
    int n;
    logic [7:0] nxt;
    n   = 0;
    nxt = exp_pc + 8'd1;
    while (bus.instr_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 16'(bus.instr_req), 16'd1);
    check("fetch_addr", 16'(bus.instr_addr), 16'(exp_pc));
    for (int i = 0; i < delay; i++) begin
      tick();
      check("req_hold", 16'(bus.instr_req), 16'd1);
      check("addr_hold", 16'(bus.instr_addr), 16'(exp_pc));
    end
    bus.instr_ack = 1'b1;
    bus.instr     = word;
    tick();
    bus.instr_ack = 1'b0;
    bus.instr     = 16'h0000;
    check("pc_inc", 16'(bus.instr_addr), 16'(nxt));
    check("req_drop", 16'(bus.instr_req), 16'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.instr_ack = 1'b0;
    bus.instr     = 16'h0000;
    tick();
    tick();

    // Reset state
    check("rst_req", 16'(bus.instr_req), 16'd0);
    check("rst_pc", 16'(bus.instr_addr), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_cy_ce", 16'(cy_ce), 16'd0);
    check("rst_alu_a", 16'(alu_a), 16'd0);
    check("rst_alu_b", 16'(alu_b), 16'd0);
    check("rst_alu_op", 16'(alu_op), 16'd0);
    check("rst_alu_ci", 16'(alu_ci), 16'd0);
    check_state("rst_state", S_IDLE);
`ifdef EXEC_CTRL_ZFLAG_EN
    check("rst_z", 16'(z), 16'd0);
`endif

    // Stay in IDLE without start; stray ack is ignored
    rst_n = 1'b1;
    tick();
    bus.instr_ack = 1'b1;
    bus.instr     = 16'hF000;
    tick();
    bus.instr_ack = 1'b0;
    tick();
    check_state("idle_hold", S_IDLE);
    check("idle_pc", 16'(bus.instr_addr), 16'd0);
    check("idle_busy", 16'(busy), 16'd0);

    // addr0: ADD R0,#05 wb -> R0=05; 4-cycle latency; one-cycle cy_ce
    do_start();
    check("start_busy", 16'(busy), 16'd1);
    fetch(16'h8405, 0, 8'h00);
    check_state("a0_decode", S_DECODE);
    tick();
    check_state("a0_exec", S_EXEC);
    check("a0_alu_a", 16'(alu_a), 16'h00);
    check("a0_alu_b", 16'(alu_b), 16'h05);
    check("a0_alu_op", 16'(alu_op), 16'd0);
    check("a0_cy_ce_exec", 16'(cy_ce), 16'd0);
    tick();
    check_state("a0_wb", S_WB);
    check("a0_cy_ce_wb", 16'(cy_ce), 16'd1);
    check("a0_busy", 16'(busy), 16'd1);
    tick();
    check_state("a0_next_fetch", S_FETCH);
    check("a0_cy_ce_after", 16'(cy_ce), 16'd0);

    // addr1: ADD R1,#FF wb; start during execution is ignored
    fetch(16'h85FF, 0, 8'h01);
    start = 1'b1;
    tick();
    check("a1_alu_a", 16'(alu_a), 16'h00);
    check("a1_alu_b", 16'(alu_b), 16'hFF);
    tick();
    start = 1'b0;
    check_state("a1_wb_start_ignored", S_WB);
    tick();

    // addr2: HALT -> halted, PC=3
    fetch(16'hF000, 0, 8'h02);
    tick();
    check_state("halt_state", S_HALT);
    check("halt_halted", 16'(halted), 16'd1);
    check("halt_busy", 16'(busy), 16'd0);
    check("halt_pc", 16'(bus.instr_addr), 16'h03);
    check("halt_req", 16'(bus.instr_req), 16'd0);
    tick();
    tick();
    check("halt_stays", 16'(halted), 16'd1);

    // Restart from HALT; addr3: ADD R1,#01 with ack delayed 3 cycles
    do_start();
    check("restart_halted", 16'(halted), 16'd0);
    fetch(16'h8501, 3, 8'h03);
    tick();
    check("a3_alu_a", 16'(alu_a), 16'hFF);
    check("a3_alu_b", 16'(alu_b), 16'h01);
    check("a3_alu_ci", 16'(alu_ci), 16'd0);
    tick();
    check("a3_cy_ce", 16'(cy_ce), 16'd1);
    check("a3_res", 16'(dbg.res), 16'h00);
    check("a3_res_cy", 16'(dbg.res_cy), 16'd1);
    tick();
`ifdef EXEC_CTRL_ZFLAG_EN
    check("a3_z", 16'(z), 16'd1);
`endif

    // addr4: AND R0,R1 ci_en, no wb -> operands R0=05, R1=00, ci=carry(1)
    fetch(16'h2801, 0, 8'h04);
    tick();
    check("a4_alu_a", 16'(alu_a), 16'h05);
    check("a4_alu_b", 16'(alu_b), 16'h00);
    check("a4_alu_op", 16'(alu_op), 16'd2);
    check("a4_alu_ci", 16'(alu_ci), 16'd1);
    tick();
    check("a4_cy_ce", 16'(cy_ce), 16'd1);
    tick();
`ifdef EXEC_CTRL_ZFLAG_EN
    check("a4_z_hold", 16'(z), 16'd1);
`endif

    // addr5: SUB R0,#01 wb -> R0=04; op 001 never loads carry
    fetch(16'h9401, 0, 8'h05);
    tick();
    check("a5_alu_a", 16'(alu_a), 16'h05);
    tick();
    check("a5_cy_ce", 16'(cy_ce), 16'd0);
    tick();
`ifdef EXEC_CTRL_ZFLAG_EN
    check("a5_z", 16'(z), 16'd0);
`endif

    // addr6: op110 R2<=R0 (reg source); ack while req low is ignored
    fetch(16'h6600, 0, 8'h06);
    bus.instr_ack = 1'b1;
    bus.instr     = 16'hF000;
    tick();
    bus.instr_ack = 1'b0;
    bus.instr     = 16'h0000;
    check("a6_stray_ack_pc", 16'(bus.instr_addr), 16'h07);
    check_state("a6_exec", S_EXEC);
    check("a6_alu_b", 16'(alu_b), 16'h04);
    check("a6_alu_op", 16'(alu_op), 16'd6);
    tick();
    check("a6_cy_ce", 16'(cy_ce), 16'd0);
    tick();

    // addr7: op111 with imm_sel=0 is not HALT; R3 vs R2
    fetch(16'h7302, 0, 8'h07);
    tick();
    check_state("a7_exec", S_EXEC);
    check("a7_alu_b", 16'(alu_b), 16'h04);
    check("a7_alu_op", 16'(alu_op), 16'd7);
    tick();
    check("a7_cy_ce", 16'(cy_ce), 16'd0);
    tick();

    // Run no-write instructions up to PC=0xFF, then wrap to 0x00
    for (int p = 8; p < 256; p++) begin
      fetch(16'h9000, 0, 8'(p));
      tick();
      tick();
      tick();
    end
    check("pc_wrap", 16'(bus.instr_addr), 16'h00);

    // HALT at 0, restart, then reset mid-fetch with request pending
    fetch(16'hF000, 0, 8'h00);
    tick();
    check("halt2_pc", 16'(bus.instr_addr), 16'h01);
    do_start();
    check("midfetch_req", 16'(bus.instr_req), 16'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_req", 16'(bus.instr_req), 16'd0);
    check("rst_async_pc", 16'(bus.instr_addr), 16'd0);
    check("rst_async_busy", 16'(busy), 16'd0);
    check_state("rst_async_state", S_IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    check_state("post_rst_idle", S_IDLE);

    // Register file cleared: ADD R0,#00 no wb shows R0=00 on operand A
    do_start();
    fetch(16'h8000, 0, 8'h00);
    tick();
    check("rf_reset_r0", 16'(alu_a), 16'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
